ex_stage: RTL

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/ex_stage.sv
// Execute stage: ID/EX and EX/MEM pipeline registers, operand forwarding,
// ALU, branch-zero flag and load-use stall detection.
module ex_stage #(
  parameter int W  = 8,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [3:0]    id_alu_ctrl,
  input  logic          id_alu_src,
  input  logic [W-1:0]  id_imm,
  input  logic [W-1:0]  id_rs1_data,
  input  logic [W-1:0]  id_rs2_data,
  input  logic [RW-1:0] id_rs1,
  input  logic [RW-1:0] id_rs2,
  input  logic [RW-1:0] id_rd,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          id_branch,
  input  logic          flush,
  input  logic          wb_reg_write,
  input  logic [RW-1:0] wb_rd,
  input  logic [W-1:0]  wb_data,
  output logic          ex_stall,
  output logic          mem_valid,
  output logic [W-1:0]  mem_alu_result,
  output logic [W-1:0]  mem_store_data,
  output logic [RW-1:0] mem_rd,
  output logic          mem_reg_write,
  output logic          mem_read,
  output logic          mem_write,
  output logic          mem_zero,
  output logic          mem_branch_taken
);

  typedef struct packed {
    logic          valid;
    logic [3:0]    alu_ctrl;
    logic          alu_src;
    logic [W-1:0]  imm;
    logic [W-1:0]  rs1_data;
    logic [W-1:0]  rs2_data;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
    logic [RW-1:0] rd;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic          branch;
  } idex_t;

  typedef struct packed {
    logic          valid;
    logic [W-1:0]  alu_result;
    logic [W-1:0]  store_data;
    logic [RW-1:0] rd;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic          zero;
    logic          branch_taken;
  } exmem_t;

  idex_t  idex_q, idex_d;
  exmem_t exmem_q, exmem_d;

  logic          mem_fwd_ok;
  logic          hit_mem_a, hit_mem_b;
  logic          hit_wb_a, hit_wb_b;
  logic [W-1:0]  op_a, fwd_b, op_b;
  logic [W-1:0]  alu_res;

  // Load-use: the load in EX cannot supply data until it reaches WB.
  assign ex_stall = !flush && id_valid
                 && idex_q.valid && idex_q.mem_read
                 && (idex_q.rd != '0)
                 && ((idex_q.rd == id_rs1) || (idex_q.rd == id_rs2));

  always_comb begin
    idex_d           = '0;
    idex_d.valid     = id_valid;
    idex_d.alu_ctrl  = id_alu_ctrl;
    idex_d.alu_src   = id_alu_src;
    idex_d.imm       = id_imm;
    idex_d.rs1_data  = id_rs1_data;
    idex_d.rs2_data  = id_rs2_data;
    idex_d.rs1       = id_rs1;
    idex_d.rs2       = id_rs2;
    idex_d.rd        = id_rd;
    idex_d.reg_write = id_reg_write;
    idex_d.mem_read  = id_mem_read;
    idex_d.mem_write = id_mem_write;
    idex_d.branch    = id_branch;
    if (flush || ex_stall) begin
      idex_d = '0;
    end
  end

  // A load result in EX/MEM is only an address, so it is never forwarded.
  assign mem_fwd_ok = exmem_q.valid && exmem_q.reg_write
                   && !exmem_q.mem_read && (exmem_q.rd != '0);

  assign hit_mem_a = mem_fwd_ok && (exmem_q.rd == idex_q.rs1);
  assign hit_mem_b = mem_fwd_ok && (exmem_q.rd == idex_q.rs2);
  assign hit_wb_a  = wb_reg_write && (wb_rd != '0)
                  && (wb_rd == idex_q.rs1);
  assign hit_wb_b  = wb_reg_write && (wb_rd != '0)
                  && (wb_rd == idex_q.rs2);

  assign op_a  = hit_mem_a ? exmem_q.alu_result
               : hit_wb_a  ? wb_data
               :             idex_q.rs1_data;
  assign fwd_b = hit_mem_b ? exmem_q.alu_result
               : hit_wb_b  ? wb_data
               :             idex_q.rs2_data;
  assign op_b  = idex_q.alu_src ? idex_q.imm : fwd_b;

  always_comb begin
    alu_res = '0;
    case (idex_q.alu_ctrl)
      4'b0000: alu_res = op_a & op_b;
      4'b0001: alu_res = op_a | op_b;
      4'b0010: alu_res = op_a + op_b;
      4'b0110: alu_res = op_a - op_b;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    exmem_d = '0;
    if (idex_q.valid) begin
      exmem_d.valid        = 1'b1;
      exmem_d.alu_result   = alu_res;
      exmem_d.store_data   = fwd_b;
      exmem_d.rd           = idex_q.rd;
      exmem_d.reg_write    = idex_q.reg_write;
      exmem_d.mem_read     = idex_q.mem_read;
      exmem_d.mem_write    = idex_q.mem_write;
      exmem_d.zero         = (alu_res == '0);
      exmem_d.branch_taken = idex_q.branch && (alu_res == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idex_q  <= '0;
      exmem_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= flush ? '0 : exmem_d;
    end
  end

  assign mem_valid        = exmem_q.valid;
  assign mem_alu_result   = exmem_q.alu_result;
  assign mem_store_data   = exmem_q.store_data;
  assign mem_rd           = exmem_q.rd;
  assign mem_reg_write    = exmem_q.reg_write;
  assign mem_read         = exmem_q.mem_read;
  assign mem_write        = exmem_q.mem_write;
  assign mem_zero         = exmem_q.zero;
  assign mem_branch_taken = exmem_q.branch_taken;

endmodule
